operand_fetch_stage: RTL and testbench

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/operand_fetch_stage.sv | 143 ++++++++++++++
 tb/tb_operand_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage for a MIPS-style pipeline.
// Decodes source/destination registers, forwards same-cycle writeback data,
// tracks pending register writes in a scoreboard to detect RAW hazards, and
// registers the operand bundle behind a valid/ready handshake.
module operand_fetch_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  output logic [4:0]             Aa,
  output logic [4:0]             Ab,
  input  logic [31:0]            Da,
  input  logic [31:0]            Db,
  input  logic                   wb_en,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_opA,
  output logic [31:0]            out_opB,
  output logic [31:0]            out_imm,
  output logic [4:0]             out_dest,
  output logic [5:0]             out_opcode,
  output logic [5:0]             out_funct,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [4:0]  dest;
  logic        rs_src, rt_src;
  logic        rs_wb_hit, rt_wb_hit;
  logic [31:0] opa, opb, imm;
  logic        hazard, accept;

  logic [31:0]            sb_q, sb_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            opa_q, opb_q, imm_q;
  logic [4:0]             dest_q;
  logic [5:0]             opcode_q, funct_q;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm    = {{16{instr[15]}}, instr[15:0]};
  assign Aa     = rs;
  assign Ab     = rt;

  // Destination register and source-usage decode from the opcode.
  always_comb begin
    dest   = rt;
    rs_src = 1'b1;
    rt_src = 1'b0;
    case (opcode)
      OP_RTYPE: begin dest = rd;    rt_src = 1'b1; end
      OP_JAL:   begin dest = 5'd31; rs_src = 1'b0; end
      OP_J:     begin dest = 5'd0;  rs_src = 1'b0; end
      OP_SW, OP_BEQ, OP_BNE: begin dest = 5'd0; rt_src = 1'b1; end
      default:  ;
    endcase
  end

  // A writeback landing this cycle both forwards its data and resolves the hazard.
  assign rs_wb_hit = wb_en && (wb_addr == rs);
  assign rt_wb_hit = wb_en && (wb_addr == rt);
  assign opa = (rs == 5'd0) ? 32'd0 : (rs_wb_hit ? wb_data : Da);
  assign opb = (rt == 5'd0) ? 32'd0 : (rt_wb_hit ? wb_data : Db);

  assign hazard = in_valid && ((rs_src && sb_q[rs] && !rs_wb_hit) ||
                               (rt_src && sb_q[rt] && !rt_wb_hit));
  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Scoreboard update: writeback clears first so a same-cycle new claim wins.
  always_comb begin
    sb_d = sb_q;
    if (wb_en && (wb_addr != 5'd0)) sb_d[wb_addr] = 1'b0;
    if (accept && (dest != 5'd0))   sb_d[dest]    = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Saturating count of cycles spent blocked on a hazard.
  always_comb begin
    stall_d = stall_q;
    if (hazard && !(&stall_q)) stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  // Output bundle valid: set on accept, dropped once consumed downstream.
  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // State registers; bundle fields load only on accept so they stay stable while held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q        <= 32'd0;
      stall_q     <= '0;
      out_valid_q <= 1'b0;
      opa_q       <= 32'd0;
      opb_q       <= 32'd0;
      imm_q       <= 32'd0;
      dest_q      <= 5'd0;
      opcode_q    <= 6'd0;
      funct_q     <= 6'd0;
    end else begin
      sb_q        <= sb_d;
      stall_q     <= stall_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        opa_q    <= opa;
        opb_q    <= opb;
        imm_q    <= imm;
        dest_q   <= dest;
        opcode_q <= opcode;
        funct_q  <= instr[5:0];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opA     = opa_q;
  assign out_opB     = opb_q;
  assign out_imm     = imm_q;
  assign out_dest    = dest_q;
  assign out_opcode  = opcode_q;
  assign out_funct   = funct_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Testbench for operand_fetch_stage: directed vector table, hand-written
// saturation/reset sequence, and randomized cycles against a behavioural model.
module tb_operand_fetch_stage;

  localparam int W = 4;
  localparam int SMAX = (1 << W) - 1;

  logic        clk, reset_n, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [31:0] instr, Da, Db, wb_data, out_opA, out_opB, out_imm;
  logic [4:0]  Aa, Ab, wb_addr, out_dest;
  logic [5:0]  out_opcode, out_funct;
  logic [W-1:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  operand_fetch_stage #(.STALL_CNT_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .Aa(Aa), .Ab(Ab), .Da(Da), .Db(Db), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_opA(out_opA), .out_opB(out_opB),
    .out_imm(out_imm), .out_dest(out_dest), .out_opcode(out_opcode),
    .out_funct(out_funct), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ins, da, db;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        ordy;
    logic        e_rdy, e_ov;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_d;
    int          e_s;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic vec_t mkv(input logic iv, input logic [31:0] ins, input logic [31:0] da,
                               input logic [31:0] db, input logic wbe, input logic [4:0] wba,
                               input logic [31:0] wbd, input logic ordy, input logic e_rdy,
                               input logic e_ov, input logic [31:0] e_a, input logic [31:0] e_b,
                               input logic [4:0] e_d, input int e_s);
    vec_t v;
    v.iv = iv; v.ins = ins; v.da = da; v.db = db; v.wbe = wbe; v.wba = wba; v.wbd = wbd;
    v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_a = e_a; v.e_b = e_b; v.e_d = e_d;
    v.e_s = e_s;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] da,
                       input logic [31:0] db, input logic wbe, input logic [4:0] wba,
                       input logic [31:0] wbd, input logic ordy);
    in_valid = iv; instr = ins; Da = da; Db = db;
    wb_en = wbe; wb_addr = wba; wb_data = wbd; out_ready = ordy;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".opA"}, out_opA, 0);
    chk({tag, ".opB"}, out_opB, 0);
    chk({tag, ".imm"}, out_imm, 0);
    chk({tag, ".dest"}, out_dest, 0);
    chk({tag, ".opcode"}, out_opcode, 0);
    chk({tag, ".funct"}, out_funct, 0);
    chk({tag, ".stall"}, stall_count, 0);
  endtask

  // Behavioural model state for the random phase
  bit          pend[32];
  logic        m_ov;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_d;
  logic [5:0]  m_op, m_fn;
  int          m_stall;

  function automatic bit reads_rs(input logic [5:0] op);
    return !(op == 6'h02 || op == 6'h03);
  endfunction

  function automatic bit reads_rt(input logic [5:0] op);
    return (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05);
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h00) return ins[15:11];
    if (op == 6'h03) return 5'd31;
    if (op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h02) return 5'd0;
    return ins[20:16];
  endfunction

  initial begin
    logic [5:0] ops[9];
    logic [31:0] ins;
    logic [5:0]  op;
    logic [4:0]  rs, rt, d;
    logic        iv, wbe, ordy, hz, erdy, acc;
    logic [4:0]  wba;
    logic [31:0] wbd, da, db;

    ops = '{6'h00, 6'h08, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h23, 6'h0D};

    tbl[0]  = mkv(1, rtype(2, 3, 4, 6'h21), 5, 7, 0, 0, 0, 1,       1, 1, 5, 7, 4, 0);
    tbl[1]  = mkv(1, itype(6'h08, 0, 25, 16'd420), 99, 88, 0, 0, 0, 1, 1, 1, 0, 88, 25, 0);
    tbl[2]  = mkv(0, rtype(25, 4, 8, 6'h21), 0, 0, 1, 4, 123, 1,    1, 0, 0, 88, 25, 0);
    tbl[3]  = mkv(1, rtype(25, 4, 8, 6'h21), 1, 2, 0, 0, 0, 1,      0, 0, 0, 88, 25, 1);
    tbl[4]  = mkv(1, rtype(25, 4, 8, 6'h21), 1, 2, 0, 0, 0, 1,      0, 0, 0, 88, 25, 2);
    tbl[5]  = mkv(1, rtype(25, 4, 8, 6'h21), 1, 2, 1, 25, 420, 1,   1, 1, 420, 2, 8, 2);
    tbl[6]  = mkv(1, rtype(0, 0, 10, 6'h21), 69, 69, 1, 0, 69, 1,   1, 1, 0, 0, 10, 2);
    tbl[7]  = mkv(1, rtype(0, 0, 11, 6'h21), 3, 4, 0, 0, 0, 0,      0, 1, 0, 0, 10, 2);
    tbl[8]  = mkv(1, rtype(0, 0, 11, 6'h21), 3, 4, 0, 0, 0, 0,      0, 1, 0, 0, 10, 2);
    tbl[9]  = mkv(1, rtype(0, 0, 11, 6'h21), 3, 4, 0, 0, 0, 0,      0, 1, 0, 0, 10, 2);
    tbl[10] = mkv(1, rtype(0, 0, 11, 6'h21), 3, 4, 0, 0, 0, 1,      1, 1, 0, 0, 11, 2);
    tbl[11] = mkv(1, itype(6'h08, 0, 9, 16'd5), 6, 6, 1, 9, 77, 1,  1, 1, 0, 77, 9, 2);
    tbl[12] = mkv(1, rtype(9, 0, 12, 6'h21), 1, 1, 0, 0, 0, 1,      0, 0, 0, 77, 9, 3);
    tbl[13] = mkv(1, itype(6'h04, 0, 9, 16'd16), 2, 3, 1, 9, 55, 1, 1, 1, 0, 55, 0, 3);
    tbl[14] = mkv(1, itype(6'h08, 0, 8, 16'd1), 2, 44, 0, 0, 0, 1,  1, 1, 0, 44, 8, 3);
    tbl[15] = mkv(1, itype(6'h03, 10, 0, 16'd0), 3, 9, 0, 0, 0, 1,  1, 1, 3, 0, 31, 3);

    // Reset state, checked while reset is still asserted
    reset_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    #12;
    chk_all_zero("reset");
    chk("reset.in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].ins, tbl[i].da, tbl[i].db, tbl[i].wbe, tbl[i].wba,
            tbl[i].wbd, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d.Aa", i), Aa, tbl[i].ins[25:21]);
      chk($sformatf("tbl%0d.Ab", i), Ab, tbl[i].ins[20:16]);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d.opA", i), out_opA, tbl[i].e_a);
      chk($sformatf("tbl%0d.opB", i), out_opB, tbl[i].e_b);
      chk($sformatf("tbl%0d.dest", i), out_dest, tbl[i].e_d);
      chk($sformatf("tbl%0d.stall", i), stall_count, tbl[i].e_s);
      $display("vector %0d: instr=%08h in_ready=%0b out_valid=%0b opA=%0h opB=%0h dest=%0d stall=%0d",
               i, tbl[i].ins, in_ready, out_valid, out_opA, out_opB, out_dest, stall_count);
    end

    // Stall saturation, then reset in the middle of a stall
    do_reset();
    drive(1, itype(6'h08, 0, 5, 16'hFFFF), 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("sat.setup_imm", out_imm, 32'hFFFF_FFFF);
    chk("sat.setup_dest", out_dest, 5);
    drive(1, rtype(5, 0, 6, 6'h21), 32'h1234, 0, 0, 0, 0, 1);
    for (int c = 1; c <= (1 << W) + 2; c++) begin
      #1;
      chk($sformatf("sat%0d.in_ready", c), in_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("sat%0d.stall", c), stall_count, (c > SMAX) ? SMAX : c);
    end
    $display("saturation: stall_count=%0d after %0d hazard cycles", stall_count, (1 << W) + 2);
    reset_n = 1'b0;
    #2;
    chk_all_zero("midreset");
    chk("midreset.in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("postreset.in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("postreset.out_valid", out_valid, 1);
    chk("postreset.dest", out_dest, 6);
    chk("postreset.opA", out_opA, 32'h1234);
    chk("postreset.stall", stall_count, 0);
    $display("reset mid-stall: out_valid=%0b dest=%0d stall=%0d", out_valid, out_dest, stall_count);

    // Randomized cycles against the behavioural model
    do_reset();
    foreach (pend[r]) pend[r] = 0;
    m_ov = 0; m_a = 0; m_b = 0; m_imm = 0; m_d = 0; m_op = 0; m_fn = 0; m_stall = 0;
    for (int c = 0; c < 300; c++) begin
      op   = ops[$urandom_range(0, 8)];
      rs   = 5'($urandom_range(0, 7));
      rt   = 5'($urandom_range(0, 7));
      ins  = {op, rs, rt, 16'($urandom)};
      iv   = ($urandom_range(0, 3) != 0);
      wbe  = ($urandom_range(0, 1) != 0);
      wba  = 5'($urandom_range(0, 7));
      wbd  = $urandom;
      da   = $urandom;
      db   = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      drive(iv, ins, da, db, wbe, wba, wbd, ordy);

      hz = iv && ((reads_rs(op) && pend[rs] && !(wbe && wba == rs)) ||
                  (reads_rt(op) && pend[rt] && !(wbe && wba == rt)));
      erdy = (!m_ov || ordy) && !hz;
      acc  = iv && erdy;
      #1;
      chk($sformatf("rnd%0d.in_ready", c), in_ready, erdy);
      chk($sformatf("rnd%0d.Aa", c), Aa, rs);

      if (hz && m_stall < SMAX) m_stall++;
      if (wbe) pend[wba] = 0;
      if (acc) begin
        d = dest_of(ins);
        if (d != 0) pend[d] = 1;
        m_a   = (rs == 0) ? 32'd0 : ((wbe && wba == rs) ? wbd : da);
        m_b   = (rt == 0) ? 32'd0 : ((wbe && wba == rt) ? wbd : db);
        m_imm = {{16{ins[15]}}, ins[15:0]};
        m_d   = d;
        m_op  = op;
        m_fn  = ins[5:0];
        m_ov  = 1;
      end else if (ordy) begin
        m_ov = 0;
      end

      @(posedge clk); #1;
      chk($sformatf("rnd%0d.out_valid", c), out_valid, m_ov);
      chk($sformatf("rnd%0d.opA", c), out_opA, m_a);
      chk($sformatf("rnd%0d.opB", c), out_opB, m_b);
      chk($sformatf("rnd%0d.imm", c), out_imm, m_imm);
      chk($sformatf("rnd%0d.dest", c), out_dest, m_d);
      chk($sformatf("rnd%0d.opcode", c), out_opcode, m_op);
      chk($sformatf("rnd%0d.funct", c), out_funct, m_fn);
      chk($sformatf("rnd%0d.stall", c), stall_count, m_stall);
      $display("random %0d: instr=%08h accept=%0b out_valid=%0b dest=%0d stall=%0d",
               c, ins, acc, out_valid, out_dest, stall_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
